// File: rtl/sd_quantizer.sv
// rtl/sd_quantizer.sv - second-order CIFB sigma-delta quantizer with overload recovery (optional dither: SD_QUANTIZER_DITHER_EN)
module sd_quantizer #(
  parameter int IN_W      = 47,
  parameter int IN_N      = 22,
  parameter int ACC_W     = 52,
  parameter int OVL_LIM   = 4,
  parameter int OVL_CYC   = 16,
  parameter int FLUSH_CYC = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enb,
  input  logic signed [IN_W-1:0] filt_in,
  output logic                   bit_out,
  output logic                   overload,
  output logic [15:0]            ovl_count
);

  // Wide working width: two feedback terms plus one input word cannot overflow it.
  localparam int SW = ACC_W + 3;
  localparam int CW = $clog2(OVL_CYC + 1);
  localparam int FW = $clog2(FLUSH_CYC + 1);

  localparam logic signed [SW-1:0] FS_W    = SW'(1) << IN_N;
  localparam logic signed [SW-1:0] SAT_HI  = (SW'(1) << (ACC_W - 1)) - SW'(1);
  localparam logic signed [SW-1:0] SAT_LO  = -(SW'(1) << (ACC_W - 1));
  localparam logic signed [ACC_W:0] OVL_THR = (ACC_W + 1)'(OVL_LIM) << IN_N;
  localparam logic signed [ACC_W:0] OVL_NEG = -((ACC_W + 1)'(OVL_LIM) << IN_N);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(OVL_CYC);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_next;

  logic signed [ACC_W-1:0] i1, i2;
  logic signed [ACC_W-1:0] i1_nxt, i2_nxt;
  logic signed [SW-1:0]    in_ext, fb_ext, i1_sum, i2_sum;
  logic signed [ACC_W:0]   i2_wide;
  logic                    over;
  logic                    dec_bit;
  logic [CW-1:0]           hold_cnt, hold_inc;
  logic [FW-1:0]           flush_cnt;
  logic                    flushing, flush_enter;

  function automatic logic signed [SW-1:0] sext(input logic signed [ACC_W-1:0] v);
    return {{(SW - ACC_W){v[ACC_W-1]}}, v};
  endfunction

  // Clamp to the integrator range instead of wrapping.
  function automatic logic signed [ACC_W-1:0] sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] c;
    if (v > SAT_HI)
      c = SAT_HI;
    else if (v < SAT_LO)
      c = SAT_LO;
    else
      c = v;
    return c[ACC_W-1:0];
  endfunction

  // Loop arithmetic for the current sample: both integrators and the over-threshold test.
  always_comb begin
    in_ext  = {{(SW - IN_W){filt_in[IN_W-1]}}, filt_in};
    fb_ext  = bit_out ? FS_W : -FS_W;
    i1_sum  = sext(i1) + in_ext - fb_ext;
    i1_nxt  = sat(i1_sum);
    i2_sum  = sext(i2) + sext(i1_nxt) - (fb_ext <<< 1);
    i2_nxt  = sat(i2_sum);
    i2_wide = {i2_nxt[ACC_W-1], i2_nxt};
    over    = (i2_wide > OVL_THR) || (i2_wide < OVL_NEG);
    hold_inc = hold_cnt + CW'(1);
  end

`ifdef SD_QUANTIZER_DITHER_EN
  localparam logic signed [SW-1:0] DITHER = SW'(1) << (IN_N - 8);
  localparam logic signed [SW-1:0] ZERO_W = '0;

  logic [15:0]          lfsr;
  logic signed [SW-1:0] dec_val;

  // Galois LFSR (x^16+x^14+x^13+x^11+1), one step per sample.
  always_ff @(posedge clk) begin
    if (reset)
      lfsr <= 16'hACE1;
    else if (enb)
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Dither perturbs only the sign decision, never the stored integrator.
  always_comb begin
    dec_val = sext(i2_nxt) + (lfsr[0] ? DITHER : ZERO_W);
    dec_bit = (dec_val >= ZERO_W);
  end
`else
  // Plain sign decision on the updated second integrator.
  always_comb begin
    dec_bit = ~i2_nxt[ACC_W-1];
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= RUN;
    else
      state <= state_next;
  end

  // Next-state logic; an in-range sample always wins because over is a single test.
  always_comb begin
    state_next = state;
    if (enb) begin
      case (state)
        RUN: begin
          if (over)
            state_next = (OVL_CYC <= 1) ? FLUSH : HOLD;
        end
        HOLD: begin
          if (!over)
            state_next = RUN;
          else if (hold_inc >= HOLD_LAST)
            state_next = FLUSH;
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST)
            state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  // Decoded outputs of the state machine.
  always_comb begin
    overload    = (state != RUN);
    flushing    = (state == FLUSH);
    flush_enter = (state != FLUSH) && (state_next == FLUSH);
  end

  // Over-threshold run length, flush length and recovery event counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt  <= '0;
      flush_cnt <= '0;
      ovl_count <= '0;
    end else if (enb) begin
      if (state_next == HOLD)
        hold_cnt <= (state == HOLD) ? hold_inc : CW'(1);
      else
        hold_cnt <= '0;

      if (flushing && state_next == FLUSH)
        flush_cnt <= flush_cnt + FW'(1);
      else
        flush_cnt <= '0;

      if (flush_enter && ovl_count != 16'hFFFF)
        ovl_count <= ovl_count + 16'd1;
    end
  end

  // Integrators and output bit; flush zeroes the loop and emits a 1,0,1,0 pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      i1      <= '0;
      i2      <= '0;
      bit_out <= 1'b0;
    end else if (enb) begin
      if (flushing) begin
        i1      <= '0;
        i2      <= '0;
        bit_out <= ~flush_cnt[0];
      end else if (flush_enter) begin
        i1      <= '0;
        i2      <= '0;
        bit_out <= dec_bit;
      end else begin
        i1      <= i1_nxt;
        i2      <= i2_nxt;
        bit_out <= dec_bit;
      end
    end
  end

endmodule
